// File: rtl/jtbubl_gfx_rom_slot.sv
// -----------------------------------------------------------------------------
// jtbubl_gfx_rom_slot
//
// SDRAM-side responder for the gfx tile fetcher. A tile-ROM request
// (rom_cs/rom_addr) is answered from a small tag-matched cache of 32-bit
// words. On a miss, one SDRAM read is issued and its data fills the cache.
// rom_ok is high only while the presented address matches valid cached data.
//
// Optional build macro:
//   JTBUBL_ROMSLOT_2WAY_EN : two cache entries with a 1-bit LRU pointer, so the
//                            code0/code1 rows of a tile pair can both stay
//                            resident. Undefined: a single entry.
//
// Parameters:
//   AW     : client address width (rom_addr, 16-bit word units)
//   SW     : SDRAM word-address width
//   OFFSET : SDRAM base of the gfx ROM region, added to rom_addr (wraps)
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   downloading   : ROM load in progress; flushes the cache, blocks requests
//   rom_cs        : client request strobe
//   rom_addr      : client address
//   rom_data      : cached word for the matching address
//   rom_ok        : rom_data is valid for the current rom_addr
//   sdram_req     : SDRAM read request, level, held until sdram_ack
//   sdram_addr    : SDRAM read address
//   sdram_ack     : arbiter accepted the request (1-cycle pulse)
//   data_dst      : data on data_read belongs to this slot
//   data_rdy      : data_read valid strobe
//   data_read     : SDRAM read data
// -----------------------------------------------------------------------------
module jtbubl_gfx_rom_slot #(
   parameter int              AW     = 18,
   parameter int              SW     = 22,
   parameter logic [SW-1:0]   OFFSET = 22'h0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,
   input  logic          rom_cs,
   input  logic [AW-1:0] rom_addr,
   output logic [31:0]   rom_data,
   output logic          rom_ok,
   output logic          sdram_req,
   output logic [SW-1:0] sdram_addr,
   input  logic          sdram_ack,
   input  logic          data_dst,
   input  logic          data_rdy,
   input  logic [31:0]   data_read
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]    r_state;
   logic [AW-1:0] r_req_addr;
   logic          r_drop;
   logic          r_sdram_req;
   logic [SW-1:0] r_sdram_addr;

   logic          r_valid0;
   logic [AW-1:0] r_tag0;
   logic [31:0]   r_data0;

   logic          w_hit0;
   logic          w_hit;
   logic          w_keep;

`ifdef JTBUBL_ROMSLOT_2WAY_EN
   logic          r_valid1;
   logic [AW-1:0] r_tag1;
   logic [31:0]   r_data1;
   logic          r_lru;
   logic          w_hit1;
   logic          w_hit_way;
   logic          w_victim;
`endif

   assign w_hit0 = r_valid0 && (r_tag0 == rom_addr);

`ifdef JTBUBL_ROMSLOT_2WAY_EN
   assign w_hit1    = r_valid1 && (r_tag1 == rom_addr);
   assign w_hit     = w_hit0 || w_hit1;
   assign w_hit_way = w_hit1;
   // A hit seen on the fill edge makes that entry MRU first, so the fill
   // replaces the other one.
   assign w_victim  = rom_ok ? ~w_hit_way : r_lru;
   assign rom_data  = w_hit1 ? r_data1 : r_data0;
`else
   assign w_hit     = w_hit0;
   assign rom_data  = r_data0;
`endif

   assign rom_ok     = rom_cs && w_hit && !downloading;
   assign sdram_req  = r_sdram_req;
   assign sdram_addr = r_sdram_addr;

   // Fill is accepted only in WAIT and only if no download overlapped the
   // outstanding request; otherwise the handshake completes with no fill.
   assign w_keep = (r_state == S_WAIT) && data_rdy && data_dst &&
                   !r_drop && !downloading;

   // Request FSM: at most one outstanding SDRAM read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_addr   <= '0;
         r_drop       <= 1'b0;
         r_sdram_req  <= 1'b0;
         r_sdram_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (rom_cs && !w_hit && !downloading) begin
                  r_req_addr   <= rom_addr;
                  r_sdram_addr <= OFFSET + SW'(rom_addr);
                  r_sdram_req  <= 1'b1;
                  r_drop       <= 1'b0;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (downloading) r_drop <= 1'b1;
               if (sdram_ack) begin
                  r_sdram_req <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (downloading) r_drop <= 1'b1;
               if (data_rdy && data_dst) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Cache storage
`ifdef JTBUBL_ROMSLOT_2WAY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid0 <= 1'b0;
         r_tag0   <= '0;
         r_data0  <= '0;
         r_valid1 <= 1'b0;
         r_tag1   <= '0;
         r_data1  <= '0;
         r_lru    <= 1'b0;
      end else begin
         if (w_keep) begin
            if (w_victim) begin
               r_tag1  <= r_req_addr;
               r_data1 <= data_read;
            end else begin
               r_tag0  <= r_req_addr;
               r_data0 <= data_read;
            end
            r_lru <= ~w_victim;
         end else if (rom_ok) begin
            r_lru <= ~w_hit_way;
         end
         if (downloading) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
         end else if (w_keep) begin
            if (w_victim) r_valid1 <= 1'b1;
            else          r_valid0 <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid0 <= 1'b0;
         r_tag0   <= '0;
         r_data0  <= '0;
      end else begin
         if (downloading) begin
            r_valid0 <= 1'b0;
         end else if (w_keep) begin
            r_valid0 <= 1'b1;
            r_tag0   <= r_req_addr;
            r_data0  <= data_read;
         end
      end
   end
`endif

endmodule

// File: tb/tb_jtbubl_gfx_rom_slot.sv
`timescale 1ns/1ps
module tb_jtbubl_gfx_rom_slot;

   localparam int            AW     = 18;
   localparam int            SW     = 22;
   localparam logic [SW-1:0] OFFSET = 22'h0;
`ifdef JTBUBL_ROMSLOT_2WAY_EN
   localparam int            WAYS   = 2;
`else
   localparam int            WAYS   = 1;
`endif

   logic          clk;
   logic          rst;
   logic          downloading;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          rom_ok;
   logic          sdram_req;
   logic [SW-1:0] sdram_addr;
   logic          sdram_ack;
   logic          data_dst;
   logic          data_rdy;
   logic [31:0]   data_read;

   jtbubl_gfx_rom_slot #(.AW(AW), .SW(SW), .OFFSET(OFFSET)) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .rom_cs      (rom_cs),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .rom_ok      (rom_ok),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_dst    (data_dst),
      .data_rdy    (data_rdy),
      .data_read   (data_read)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic          ok;
      logic          chk_data;
      logic [31:0]   data;
      logic          req;
      logic [SW-1:0] addr;
   } exp_t;

   exp_t exp_q[$];

   int checks;
   int errors;

   // Stimulus-owned handshake variables read by other processes
   int            stray_cnt;
   logic          arb_slow;
   int            a_cnt;
   logic          a_req, a_ok;
   logic [31:0]   a_data;
   logic [SW-1:0] a_addr;

   // ---------------------------------------------------------------------
   // Reference model: cache as a recency-ordered list (front = most recent)
   // ---------------------------------------------------------------------
   initial begin
      logic [AW-1:0] m_tag[$];
      logic [31:0]   m_dat[$];
      int            m_pend;      // 0 none, 1 awaiting ack, 2 awaiting data
      logic          m_drop;
      logic [AW-1:0] m_paddr;
      logic [SW-1:0] m_addr;
      logic [63:0]   lsum;
      exp_t          e;
      int            hit_i;
      logic          ok;
      logic [AW-1:0] t;
      logic [31:0]   d;
      m_pend = 0; m_drop = 1'b0; m_paddr = '0; m_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_tag.delete(); m_dat.delete();
            m_pend = 0; m_drop = 1'b0; m_addr = '0;
            e.ok = 1'b0; e.chk_data = 1'b1; e.data = '0; e.req = 1'b0; e.addr = '0;
            exp_q.push_back(e);
         end else begin
            hit_i = -1;
            foreach (m_tag[i]) if (m_tag[i] == rom_addr) hit_i = i;
            ok = rom_cs && (hit_i >= 0) && !downloading;
            e.ok = ok; e.chk_data = ok;
            e.data = ok ? m_dat[hit_i] : 32'h0;
            e.req = (m_pend == 1); e.addr = m_addr;
            exp_q.push_back(e);
            if (ok) begin
               t = m_tag[hit_i]; d = m_dat[hit_i];
               m_tag.delete(hit_i); m_dat.delete(hit_i);
               m_tag.push_front(t); m_dat.push_front(d);
            end
            if (m_pend == 0) begin
               if (rom_cs && hit_i < 0 && !downloading) begin
                  m_pend = 1; m_paddr = rom_addr; m_drop = 1'b0;
                  lsum = 64'(OFFSET) + 64'(rom_addr);
                  m_addr = lsum[SW-1:0];
               end
            end else if (m_pend == 1) begin
               if (downloading) m_drop = 1'b1;
               if (sdram_ack) m_pend = 2;
            end else begin
               if (downloading) m_drop = 1'b1;
               if (data_rdy && data_dst) begin
                  if (!m_drop) begin
                     m_tag.push_front(m_paddr); m_dat.push_front(data_read);
                     if (m_tag.size() > WAYS) begin
                        void'(m_tag.pop_back()); void'(m_dat.pop_back());
                     end
                  end
                  m_pend = 0;
               end
            end
            if (downloading) begin
               m_tag.delete(); m_dat.delete();
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
      end
   endtask

   initial begin
      logic          s_ok, s_req;
      logic [31:0]   s_data;
      logic [SW-1:0] s_addr;
      exp_t          e;
      int            a_done;
      checks = 0; errors = 0; a_done = 0;
      forever begin
         @(negedge clk);
         s_ok = rom_ok; s_data = rom_data; s_req = sdram_req; s_addr = sdram_addr;
         #1;
         if (a_cnt != a_done) begin
            a_done = a_cnt;
            chk("async_rst_req",  64'(a_req),  64'(0));
            chk("async_rst_ok",   64'(a_ok),   64'(0));
            chk("async_rst_data", 64'(a_data), 64'(0));
            chk("async_rst_addr", 64'(a_addr), 64'(0));
         end
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
         end else begin
            e = exp_q.pop_front();
            chk("rom_ok",     64'(s_ok),   64'(e.ok));
            chk("sdram_req",  64'(s_req),  64'(e.req));
            chk("sdram_addr", 64'(s_addr), 64'(e.addr));
            if (e.chk_data) chk("rom_data", 64'(s_data), 64'(e.data));
         end
      end
   end

   // ---------------------------------------------------------------------
   // SDRAM arbiter responder
   // ---------------------------------------------------------------------
   initial begin
      int            ph;
      int            cnt;
      int            stray_seen;
      logic [SW-1:0] fa;
      sdram_ack = 1'b0; data_rdy = 1'b0; data_dst = 1'b0; data_read = '0;
      ph = 0; cnt = 0; stray_seen = 0; fa = '0;
      forever begin
         @(posedge clk);
         #1;
         sdram_ack = 1'b0; data_rdy = 1'b0; data_dst = 1'b0; data_read = $urandom;
         if (rst) begin
            ph = 0;
         end else if (ph == 3) begin
            data_rdy = 1'b1; data_dst = 1'b1; data_read = 32'hBAD0BAD0; ph = 0;
         end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt; sdram_ack = 1'b1; ph = 3;
         end else begin
            if (ph == 2) begin
               if (cnt == 0) begin
                  data_rdy = 1'b1; data_dst = 1'b1;
                  data_read = (fa == 22'h0000A4) ? 32'hDEADBEEF : $urandom;
                  ph = 0;
               end else cnt--;
            end
            if (ph == 0 && sdram_req && !data_rdy) begin
               fa = sdram_addr; ph = 1;
               cnt = arb_slow ? 12 : $urandom_range(0, 3);
            end
            if (ph == 1) begin
               if (cnt == 0) begin
                  sdram_ack = 1'b1; ph = 2; cnt = $urandom_range(0, 4);
               end else cnt--;
            end
         end
         if (!data_rdy) begin
            if ($urandom_range(0, 5) == 0) begin
               data_rdy = 1'b1; data_dst = 1'b0; data_read = 32'h12345678;
            end else begin
               data_dst = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Client stimulus
   // ---------------------------------------------------------------------
   task automatic drive(input logic cs, input logic [AW-1:0] a, input int n);
      @(posedge clk);
      #1;
      rom_cs = cs; rom_addr = a;
      repeat (n - 1) @(posedge clk);
   endtask

   initial begin
      logic [AW-1:0] pool[8];
      int            hold, dl;
      pool = '{18'h00010, 18'h00030, 18'h00050, 18'h000A4,
               18'h00100, 18'h00200, 18'h00040, 18'h00000};
      rst = 1'b0; downloading = 1'b0; rom_cs = 1'b0; rom_addr = '0;
      stray_cnt = 0; arb_slow = 1'b0; a_cnt = 0;
      a_req = 1'b0; a_ok = 1'b0; a_data = '0; a_addr = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // miss then hit on 0x00A4
      drive(1'b1, 18'h000A4, 20);
      drive(1'b0, 18'h000A4, 2);
      drive(1'b1, 18'h000A4, 3);

      // address change while a fetch is outstanding
      drive(1'b1, 18'h00100, 2);
      drive(1'b1, 18'h00200, 30);

      // download flush of a resident entry
      drive(1'b1, 18'h00040, 20);
      @(posedge clk); #1 downloading = 1'b1;
      repeat (6) @(posedge clk);
      #1 downloading = 1'b0;
      repeat (20) @(posedge clk);

      // reset while the request is held in REQ, then stray ack/data
      arb_slow = 1'b1;
      drive(1'b1, 18'h00300, 4);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 a_req = sdram_req; a_ok = rom_ok; a_data = rom_data; a_addr = sdram_addr;
      a_cnt++;
      rom_cs = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; arb_slow = 1'b0;
      stray_cnt++;
      repeat (4) @(posedge clk);
      drive(1'b1, 18'h00000, 20);

      // two-entry retention / single-entry eviction
      drive(1'b1, 18'h00010, 15);
      drive(1'b1, 18'h00030, 15);
      drive(1'b1, 18'h00010, 15);
      drive(1'b1, 18'h00050, 15);
      drive(1'b1, 18'h00010, 15);
      drive(1'b1, 18'h00030, 15);

      // randomized traffic
      hold = 0; dl = 0;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk);
         #1;
         if (hold == 0) begin
            hold = $urandom_range(1, 8);
            rom_addr = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) rom_addr = AW'($urandom_range(0, 255) * 2);
         end else hold--;
         rom_cs = ($urandom_range(0, 9) != 0);
         if (dl > 0) dl--;
         else if ($urandom_range(0, 60) == 0) dl = $urandom_range(1, 6);
         downloading = (dl > 0);
      end
      @(posedge clk); #1 rom_cs = 1'b0; downloading = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
